// File: rtl/interval_timer_if.sv
// Port bundle between the light FSM side and the interval timer.
// The timer drives the slave side. The controller, or a bench standing in for it, drives the master side.
//
// Handshake contract: start_timer is a one-cycle request with no ready. The timer
// always accepts it: it loads the duration on that edge and raises busy from the
// next cycle. expired is a one-cycle completion pulse with no acknowledge, and it
// is raised only in the cycle that follows the final counted tick.
interface interval_timer_if;
   logic       prog_sync;
   logic [1:0] time_selector;
   logic [3:0] time_value;
   logic       start_timer;
   logic [1:0] interval;
   logic       one_hz_enable;
   logic       expired;
   logic       busy;
   logic [3:0] remaining;
   logic       fsm_state;   // debug: 0 = IDLE, 1 = COUNT

   modport master (
      output prog_sync, time_selector, time_value, start_timer, interval, one_hz_enable,
      input  expired, busy, remaining, fsm_state
   );

   modport slave (
      input  prog_sync, time_selector, time_value, start_timer, interval, one_hz_enable,
      output expired, busy, remaining, fsm_state
   );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer for the traffic controller.
// The timer holds three reprogrammable durations: tBASE, tEXT and tYEL.
// A start request loads the chosen duration. The count then decrements on each 1 Hz tick.
// When the count runs out, the timer returns a one-cycle expired pulse.
module interval_timer #(
   parameter logic [3:0] DEF_BASE = 4'd6,
   parameter logic [3:0] DEF_EXT  = 4'd3,
   parameter logic [3:0] DEF_YEL  = 4'd2
) (
   input  logic              clk,
   input  logic              reset,   // synchronous, active low
   interval_timer_if.slave   tif
);

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [3:0] t_base, t_ext, t_yel;
   logic [3:0] rem_q, rem_d;
   logic       exp_q, exp_d;
   logic [3:0] sel_dur;

   // Duration chosen by interval, taken from the registers before any same-edge write
   always_comb begin
      sel_dur = t_base;
      case (tif.interval)
         2'b01:   sel_dur = t_ext;
         2'b10:   sel_dur = t_yel;
         default: sel_dur = t_base;
      endcase
   end

   // Duration registers: a zero value or selector 11 leaves all three unchanged
   always_ff @(posedge clk) begin
      if (!reset) begin
         t_base <= DEF_BASE;
         t_ext  <= DEF_EXT;
         t_yel  <= DEF_YEL;
      end else if (tif.prog_sync && (tif.time_value != 4'd0)) begin
         case (tif.time_selector)
            2'b00:   t_base <= tif.time_value;
            2'b01:   t_ext  <= tif.time_value;
            2'b10:   t_yel  <= tif.time_value;
            default: ;
         endcase
      end
   end

   // Next state: restart beats a same-cycle final tick, and a tick coincident with a load is not counted
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      exp_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (tif.start_timer) begin
               rem_d   = sel_dur;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (tif.start_timer) begin
               rem_d = sel_dur;
            end else if (tif.one_hz_enable) begin
               if (rem_q <= 4'd1) begin
                  rem_d   = 4'd0;
                  exp_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  rem_d = rem_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            rem_d   = 4'd0;
         end
      endcase
   end

   // State, count and expired pulse registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         rem_q   <= 4'd0;
         exp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         exp_q   <= exp_d;
      end
   end

   assign tif.expired   = exp_q;
   assign tif.busy      = (state_q == COUNT);
   assign tif.remaining = rem_q;
   assign tif.fsm_state = (state_q == COUNT);

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: a per-cycle vector table plus multi-cycle sequences.
module tb_interval_timer;

   logic clk;
   logic reset;
   interval_timer_if tif ();

   interval_timer #(.DEF_BASE(4'd6), .DEF_EXT(4'd3), .DEF_YEL(4'd2)) dut (
      .clk   (clk),
      .reset (reset),
      .tif   (tif)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       prog;
      logic [1:0] sel;
      logic [3:0] val;
      logic       start;
      logic [1:0] ivl;
      logic       tick;
      logic       e_exp;
      logic       e_busy;
      logic [3:0] e_rem;
      string      name;
   } vec_t;

   vec_t vec_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic rst, input logic prog, input logic [1:0] sel,
                               input logic [3:0] val, input logic start, input logic [1:0] ivl,
                               input logic tick, input logic e_exp, input logic e_busy,
                               input logic [3:0] e_rem, input string name);
      vec_t v;
      v.rst = rst; v.prog = prog; v.sel = sel; v.val = val; v.start = start;
      v.ivl = ivl; v.tick = tick; v.e_exp = e_exp; v.e_busy = e_busy; v.e_rem = e_rem;
      v.name = name;
      return v;
   endfunction

   // Drive one full set of inputs, then advance past the next rising edge
   task automatic drive(input logic rst, input logic prog, input logic [1:0] sel,
                        input logic [3:0] val, input logic start, input logic [1:0] ivl,
                        input logic tick);
      reset             = rst;
      tif.prog_sync     = prog;
      tif.time_selector = sel;
      tif.time_value    = val;
      tif.start_timer   = start;
      tif.interval      = ivl;
      tif.one_hz_enable = tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc(input logic tick);
      drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 2'b00, tick);
   endtask

   // Scoreboard compare: expired, busy, remaining and the debug state (which mirrors busy)
   task automatic check(input string name, input logic e_exp, input logic e_busy,
                        input logic [3:0] e_rem);
      checks++;
      if ({tif.expired, tif.busy, tif.remaining, tif.fsm_state} !== {e_exp, e_busy, e_rem, e_busy}) begin
         errors++;
         $display("FAIL %s: got expired=%b busy=%b remaining=%0d state=%b, want expired=%b busy=%b remaining=%0d state=%b",
                  name, tif.expired, tif.busy, tif.remaining, tif.fsm_state,
                  e_exp, e_busy, e_rem, e_busy);
      end
   endtask

   // Start a run of duration n with a tick every gap cycles, and follow it to expiry
   task automatic run(input string name, input logic [1:0] ivl, input int n, input int gap);
      drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b1, ivl, 1'b0);
      check({name, "_load"}, 1'b0, 1'b1, 4'(n));
      for (int k = 1; k <= n; k++) begin
         for (int g = 1; g < gap; g++) begin
            idle_cyc(1'b0);
            check({name, "_hold"}, 1'b0, 1'b1, 4'(n - k + 1));
         end
         idle_cyc(1'b1);
         if (k == n) check({name, "_expire"}, 1'b1, 1'b0, 4'd0);
         else        check({name, "_tick"}, 1'b0, 1'b1, 4'(n - k));
      end
      idle_cyc(1'b0);
      check({name, "_after"}, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      // Vector table: inputs for one cycle and the outputs expected after that edge
      vec_q.push_back(mk(0,0,2'b00,4'd0,0,2'b00,0, 0,0,4'd0, "reset"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,0, 0,0,4'd0, "idle"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,0,4'd0, "idle_tick"));
      vec_q.push_back(mk(1,1,2'b11,4'd5,0,2'b00,0, 0,0,4'd0, "prog_sel11"));
      vec_q.push_back(mk(1,1,2'b00,4'd0,0,2'b00,0, 0,0,4'd0, "prog_zero"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,1,2'b11,1, 0,1,4'd6, "start_ivl11_tick"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd5, "tick5"));
      vec_q.push_back(mk(1,1,2'b00,4'd4,0,2'b00,0, 0,1,4'd5, "prog_midcount"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd4, "tick4"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd3, "tick3"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd2, "tick2"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd1, "tick1"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 1,0,4'd0, "expire"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,0, 0,0,4'd0, "expire_one_cycle"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,1,2'b00,0, 0,1,4'd4, "start_new_base"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd3, "nb_tick3"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd2, "nb_tick2"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd1, "nb_tick1"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,1,2'b01,1, 0,1,4'd3, "restart_on_final"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd2, "rs_tick2"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,1,4'd1, "rs_tick1"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 1,0,4'd0, "rs_expire"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,0, 0,0,4'd0, "rs_idle"));
      vec_q.push_back(mk(1,1,2'b01,4'd8,1,2'b01,0, 0,1,4'd3, "prog_start_same_reg"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,1,2'b01,0, 0,1,4'd8, "restart_new_ext"));
      vec_q.push_back(mk(0,0,2'b00,4'd0,0,2'b00,1, 0,0,4'd0, "reset_abort"));
      vec_q.push_back(mk(1,0,2'b00,4'd0,0,2'b00,1, 0,0,4'd0, "after_abort"));

      foreach (vec_q[i]) begin
         drive(vec_q[i].rst, vec_q[i].prog, vec_q[i].sel, vec_q[i].val,
               vec_q[i].start, vec_q[i].ivl, vec_q[i].tick);
         check(vec_q[i].name, vec_q[i].e_exp, vec_q[i].e_busy, vec_q[i].e_rem);
      end

      // Base run with ticks every 10 cycles
      drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 1'b0);
      check("seq_reset", 1'b0, 1'b0, 4'd0);
      run("base10", 2'b00, 6, 10);

      // Program tYEL=9, then confirm that selector 11 and a zero value leave the registers alone
      drive(1'b1, 1'b1, 2'b10, 4'd9, 1'b0, 2'b00, 1'b0);
      check("prog_yel9", 1'b0, 1'b0, 4'd0);
      run("yel9", 2'b10, 9, 3);
      drive(1'b1, 1'b1, 2'b11, 4'd7, 1'b0, 2'b00, 1'b0);
      drive(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 2'b00, 1'b0);
      check("prog_noop", 1'b0, 1'b0, 4'd0);
      run("base_still6", 2'b00, 6, 1);
      run("yel_still9", 2'b10, 9, 1);

      // Program tEXT=7 mid-count: the current run keeps 3 and the next run uses 7
      drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 1'b0);
      check("ext_load", 1'b0, 1'b1, 4'd3);
      idle_cyc(1'b1);
      check("ext_tick2", 1'b0, 1'b1, 4'd2);
      drive(1'b1, 1'b1, 2'b01, 4'd7, 1'b0, 2'b00, 1'b0);
      check("ext_prog7", 1'b0, 1'b1, 4'd2);
      idle_cyc(1'b1);
      check("ext_tick1", 1'b0, 1'b1, 4'd1);
      idle_cyc(1'b1);
      check("ext_expire", 1'b1, 1'b0, 4'd0);
      run("ext7", 2'b01, 7, 2);

      // Reset at remaining=2: no pulse afterwards, and the defaults are restored
      drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 1'b0);
      check("abort_load", 1'b0, 1'b1, 4'd6);
      for (int k = 1; k <= 4; k++) idle_cyc(1'b1);
      check("abort_at2", 1'b0, 1'b1, 4'd2);
      drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 1'b1);
      check("abort_reset", 1'b0, 1'b0, 4'd0);
      for (int k = 1; k <= 4; k++) begin
         idle_cyc(1'b1);
         check("abort_quiet", 1'b0, 1'b0, 4'd0);
      end
      run("def_base", 2'b00, 6, 1);
      run("def_ext", 2'b01, 3, 1);
      run("def_yel", 2'b10, 2, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Programmable interval timer for the traffic controller.
- Holds the three reprogrammable durations: tBASE, tEXT and tYEL.
- On start_timer from the light FSM, loads the duration chosen by interval, then counts down on 1 Hz enable ticks.
- Returns a single-cycle expired pulse to the FSM.
- Sits between the input synchronisers / 1 Hz divider and the light FSM.

Parameters:
- DEF_BASE, 6, tBASE reset value in seconds (4-bit).
- DEF_EXT, 3, tEXT reset value in seconds (4-bit).
- DEF_YEL, 2, tYEL reset value in seconds (4-bit).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- prog_sync  input  1  synchronised reprogram strobe; level, one write per high cycle.
- time_selector  input  2  register to program: 00 tBASE, 01 tEXT, 10 tYEL, 11 none.
- time_value  input  4  new duration in seconds.
- start_timer  input  1  one-cycle start/restart request from FSM.
- interval  input  2  duration to run: 00 tBASE, 01 tEXT, 10 tYEL, 11 tBASE.
- one_hz_enable  input  1  one-cycle tick, once per second.
- expired  output  1  registered one-cycle pulse at end of interval.
- busy  output  1  high while counting.
- remaining  output  4  current count value (debug / display).

Behaviour:
- Reset (reset=0 at a clk edge):
  - tBASE/tEXT/tYEL <= DEF_BASE/DEF_EXT/DEF_YEL.
  - State <= IDLE, remaining=0, busy=0, expired=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-count aborts the count with no expired pulse.
- Programming:
  - On a clk edge with prog_sync=1, time_value is written to the selected register.
  - time_selector=11: no write.
  - time_value=0: ignored; register unchanged, so a duration is never 0.
  - Programming never disturbs a running count; the new value applies from the next start_timer.
  - prog_sync held high for N cycles performs N identical writes (harmless).
- Duration read:
  - start_timer samples the register value held before any same-edge write.
  - Simultaneous prog_sync and start_timer to the same register: the old value is loaded.
- FSM states: IDLE, COUNT.
  - IDLE: start_timer=1 -> remaining <= selected duration, go to COUNT, busy=1 from the next cycle.
  - COUNT, no start_timer: each one_hz_enable decrements remaining.
    - If remaining==1 at the tick: remaining <= 0, expired <= 1 for exactly one cycle, go to IDLE.
  - COUNT, start_timer=1: reload from interval and stay in COUNT (restart).
    - Restart takes priority over a same-cycle final tick: no expired pulse.
- Tick alignment:
  - one_hz_enable in the same cycle as start_timer is not counted; counting begins with the first tick after the load edge.
- Timing:
  - expired is high in the cycle after the clk edge that sampled the Nth counted tick, N = loaded duration.
  - Elapsed time from start to expired is N ticks plus up to 1 tick of phase error.
- Outputs:
  - expired is 0 in all other cycles and never asserted in IDLE except the exit cycle.
  - busy = (state==COUNT).
- Ticks and prog_sync in IDLE have no effect on the counter.

Test Plan:
- Reset then start_timer with interval=00, ticks every 10 cycles -> busy=1; remaining 6,5,4,3,2,1; expired pulses once, 1 cycle after the 6th tick; busy=0 after.
- prog_sync, time_selector=10, time_value=9, then start with interval=10 -> expired after 9 ticks; selector=11 and time_value=0 writes leave tYEL=9 / tBASE=6.
- Mid-count prog_sync tEXT=7 while running interval=01 (3) -> current run expires after 3 ticks; next interval=01 run expires after 7.
- start_timer asserted in the same cycle as the final tick -> no expired pulse; count restarts at full duration.
- reset=0 asserted at remaining=2 -> expired never pulses; registers return to 6/3/2; busy=0 next cycle.
- start_timer coincident with one_hz_enable, and prog_sync coincident with start on the same register -> the coincident tick is not counted, and the old value is loaded.
